// File: rtl/event_stretch_pkg.sv
// Shared constants and helpers for the event stretcher.
// The timer-width derivation and the count_out slice convention live here,
// so the VIO probe wiring and the bench agree with the RTL on them.
package event_stretch_pkg;

  // Ceiling log2 that can be evaluated at elaboration time.
  // The loop has a fixed bound, so synthesis can unroll it.
  function automatic int clog2(input longint unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // The timer must be able to hold HOLD_CYCLES itself, so it needs
  // clog2(HOLD_CYCLES+1) bits. For HOLD_CYCLES=1 this is a single bit.
  function automatic int timer_width(input int hold_cycles);
    return clog2(longint'(hold_cycles) + 1);
  endfunction

  // Channel ch occupies count_out[count_lsb(ch, cnt_w) +: cnt_w].
  function automatic int count_lsb(input int ch, input int cnt_w);
    return ch * cnt_w;
  endfunction

endpackage

// File: rtl/event_stretch_ch.sv
// One event channel: stretch timer, stretched level, sticky flag,
// toggle and saturating counter. Every output is registered.
module event_stretch_ch
  import event_stretch_pkg::*;
#(
  parameter int HOLD_CYCLES = 1000000,
  parameter int CNT_W       = 16,
  parameter int TW          = timer_width(HOLD_CYCLES)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pulse_i,
  input  logic             clear_i,
  output logic             level_o,
  output logic             sticky_o,
  output logic             toggle_o,
  output logic [CNT_W-1:0] count_o
);

  logic [TW-1:0]    timer_q,  timer_d;
  logic             level_q,  level_d;
  logic             sticky_q, sticky_d;
  logic             toggle_q, toggle_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Next state: a pulse outranks clear, so an event landing in the
  // same cycle as clear is kept (count 1, sticky 1) rather than lost.
  always_comb begin
    timer_d  = timer_q;
    sticky_d = sticky_q;
    toggle_d = toggle_q;
    count_d  = count_q;

    if (pulse_i) begin
      timer_d = TW'(HOLD_CYCLES);
    end else if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end

    level_d = (timer_d != '0);

    if (pulse_i) begin
      toggle_d = ~toggle_q;
      sticky_d = 1'b1;
      if (clear_i) begin
        count_d = CNT_W'(1);
      end else if (count_q != '1) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (clear_i) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end
  end

  // State registers; reset wipes the timer too, so no residual hold survives.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      timer_q  <= '0;
      level_q  <= 1'b0;
      sticky_q <= 1'b0;
      toggle_q <= 1'b0;
      count_q  <= '0;
    end else begin
      timer_q  <= timer_d;
      level_q  <= level_d;
      sticky_q <= sticky_d;
      toggle_q <= toggle_d;
      count_q  <= count_d;
    end
  end

  assign level_o  = level_q;
  assign sticky_o = sticky_q;
  assign toggle_o = toggle_q;
  assign count_o  = count_q;

endmodule

// File: rtl/event_stretch.sv
// Turns 1-clk datapath event pulses into LED/VIO observable state:
// stretched levels, sticky flags, toggles and saturating counters.
// This level only fans out clk/rstn/clear and packs count_out.
module event_stretch
  import event_stretch_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int HOLD_CYCLES = 1000000,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_CH-1:0]       pulse_in,
  input  logic                  clear,
  output logic [N_CH-1:0]       level_out,
  output logic [N_CH-1:0]       sticky_out,
  output logic [N_CH-1:0]       toggle_out,
  output logic [N_CH*CNT_W-1:0] count_out
);

  localparam int TW = timer_width(HOLD_CYCLES);

  // Reject parameter values the channel logic cannot represent.
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("event_stretch: HOLD_CYCLES must be >= 1");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("event_stretch: N_CH must be in 1..16");
  end
  if (CNT_W < 2) begin : g_bad_cntw
    $error("event_stretch: CNT_W must be >= 2");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    event_stretch_ch #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W),
      .TW          (TW)
    ) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .pulse_i  (pulse_in[g]),
      .clear_i  (clear),
      .level_o  (level_out[g]),
      .sticky_o (sticky_out[g]),
      .toggle_o (toggle_out[g]),
      .count_o  (count_out[count_lsb(g, CNT_W) +: CNT_W])
    );
  end

endmodule

// File: tb/tb_event_stretch.sv
// Directed bench for event_stretch with N_CH=4, HOLD_CYCLES=4, CNT_W=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled
// 1 time unit after the next rising edge, i.e. they reflect that edge.
module tb_event_stretch;

  import event_stretch_pkg::*;

  localparam int N_CH        = 4;
  localparam int HOLD_CYCLES = 4;
  localparam int CNT_W       = 4;

  logic                  clk;
  logic                  rstn;
  logic [N_CH-1:0]       pulse_in;
  logic                  clear;
  logic [N_CH-1:0]       level_out;
  logic [N_CH-1:0]       sticky_out;
  logic [N_CH-1:0]       toggle_out;
  logic [N_CH*CNT_W-1:0] count_out;

  int checks;
  int errors;

  event_stretch #(
    .N_CH        (N_CH),
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pulse_in   (pulse_in),
    .clear      (clear),
    .level_out  (level_out),
    .sticky_out (sticky_out),
    .toggle_out (toggle_out),
    .count_out  (count_out)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Put the DUT into a known clean state before a scenario.
  task automatic do_reset();
    rstn     = 1'b0;
    pulse_in = '0;
    clear    = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  function automatic logic [CNT_W-1:0] cnt(input int ch);
    return count_out[count_lsb(ch, CNT_W) +: CNT_W];
  endfunction

  task automatic test_reset();
    rstn     = 1'b0;
    pulse_in = 4'hF;
    clear    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({level_out, sticky_out, toggle_out, count_out} !== 28'h0) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc%0d: level=%h sticky=%h toggle=%h count=%h, required all 0",
                 c, level_out, sticky_out, toggle_out, count_out);
      end
    end
    rstn     = 1'b1;
    pulse_in = '0;
    clear    = 1'b0;
    tick();
    checks++;
    if ({level_out, sticky_out, toggle_out, count_out} !== 28'h0) begin
      errors++;
      $display("[TB] FAIL reset_release: level=%h sticky=%h toggle=%h count=%h, required all 0",
               level_out, sticky_out, toggle_out, count_out);
    end
  endtask

  task automatic test_single_pulse();
    do_reset();
    pulse_in = 4'b0001;
    tick();
    pulse_in = '0;
    checks++;
    if (sticky_out !== 4'b0001 || toggle_out !== 4'b0001 || count_out !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL single_flags: sticky=%h toggle=%h count=%h, required 1 1 0001",
               sticky_out, toggle_out, count_out);
    end
    // Level is high for HOLD_CYCLES samples, then drops.
    for (int c = 0; c < 6; c++) begin
      logic [N_CH-1:0] exp_level;
      exp_level = (c < HOLD_CYCLES) ? 4'b0001 : 4'b0000;
      checks++;
      if (level_out !== exp_level) begin
        errors++;
        $display("[TB] FAIL single_level s%0d: level=%b, required %b", c, level_out, exp_level);
      end
      tick();
    end
  endtask

  task automatic test_retrigger();
    // Pulses two edges apart: high for 6 samples, low at the 7th.
    logic [N_CH-1:0] exp_level;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      pulse_in = (c == 0 || c == 2) ? 4'b0100 : 4'b0000;
      tick();
      exp_level = (c < 6) ? 4'b0100 : 4'b0000;
      checks++;
      if (level_out !== exp_level) begin
        errors++;
        $display("[TB] FAIL retrig_level s%0d: level=%b, required %b", c, level_out, exp_level);
      end
    end
    checks++;
    if (cnt(2) !== 4'd2 || toggle_out[2] !== 1'b0 || sticky_out !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL retrig_state: count2=%0d toggle2=%b sticky=%b, required 2 0 0100",
               cnt(2), toggle_out[2], sticky_out);
    end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    pulse_in = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_cnt = (k >= 15) ? 4'd15 : CNT_W'(k);
      checks++;
      if (cnt(1) !== exp_cnt || level_out !== 4'b0010) begin
        errors++;
        $display("[TB] FAIL sat_count ev%0d: count1=%0d level=%b, required %0d 0010",
                 k, cnt(1), level_out, exp_cnt);
      end
    end
    pulse_in = '0;
    checks++;
    if (toggle_out[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_toggle: toggle1=%b, required 0", toggle_out[1]);
    end
    // Still high for 3 more samples after the last pulse, low on the 4th.
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (level_out[1] !== (c < HOLD_CYCLES) || cnt(1) !== 4'd15) begin
        errors++;
        $display("[TB] FAIL sat_tail s%0d: level1=%b count1=%0d, required %b 15",
                 c, level_out[1], cnt(1), (c < HOLD_CYCLES));
      end
    end
  endtask

  task automatic test_clear_collision();
    do_reset();
    pulse_in = 4'b0001;
    for (int k = 0; k < 5; k++) tick();
    pulse_in = '0;
    checks++;
    if (cnt(0) !== 4'd5 || toggle_out[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL coll_setup: count0=%0d toggle0=%b, required 5 1", cnt(0), toggle_out[0]);
    end
    clear    = 1'b1;
    pulse_in = 4'b1000;
    tick();
    clear    = 1'b0;
    pulse_in = '0;
    checks++;
    if (count_out !== 16'h1000 || sticky_out !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL coll_clear: count=%h sticky=%b, required 1000 1000", count_out, sticky_out);
    end
    checks++;
    if (level_out !== 4'b1001 || toggle_out !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL coll_keep: level=%b toggle=%b, required 1001 1001", level_out, toggle_out);
    end
    // A plain clear with no event zeroes the surviving channel too.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (count_out !== 16'h0000 || sticky_out !== 4'b0000 || toggle_out !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL clear_only: count=%h sticky=%b toggle=%b, required 0000 0000 1001",
               count_out, sticky_out, toggle_out);
    end
  endtask

  task automatic test_reset_mid_stretch();
    do_reset();
    pulse_in = 4'b0001;
    tick();
    pulse_in = '0;
    tick();
    checks++;
    if (level_out[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_pre: level0=%b, required 1", level_out[0]);
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (level_out !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL mid_level s%0d: level=%b, required 0000", c, level_out);
      end
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rstn     = 1'b0;
    pulse_in = '0;
    clear    = 1'b0;
    test_reset();
    test_single_pulse();
    test_retrigger();
    test_saturation();
    test_clear_collision();
    test_reset_mid_stretch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
